// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: single-outstanding load/store unit.
// Steers store lanes, extends load data, reports done/err.
module lsu_mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        lsu_write,
  output logic [4:0]  lsu_rd_addr,
  output logic [31:0] lsu_rd_data,
  output logic        done,
  output logic        err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_load;
  logic [2:0]    op_f3;
  logic [1:0]    op_lane;
  logic [4:0]    op_rd;
  logic          accept;
  logic          bad;
  logic [31:0]   st_data;
  logic [3:0]    st_mask;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_data;

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign accept        = in_valid && in_ready;

  // Reject malformed or misaligned ops before they reach memory
  always_comb begin
    bad = 1'b0;
    if (in_is_load == in_is_store)
      bad = 1'b1;
    else if (in_is_load && (in_funct3 inside {3'd3, 3'd6, 3'd7}))
      bad = 1'b1;
    else if (in_is_store && (in_funct3 > 3'd2))
      bad = 1'b1;
    else if ((in_funct3[1:0] == 2'd1) && in_addr[0])
      bad = 1'b1;
    else if ((in_funct3[1:0] == 2'd2) && (in_addr[1:0] != 2'd0))
      bad = 1'b1;
  end

  // Replicate store data across lanes and form byte enables
  always_comb begin
    st_data = in_wdata;
    st_mask = 4'b1111;
    unique case (in_funct3[1:0])
      2'd0: begin
        st_data = {4{in_wdata[7:0]}};
        st_mask = 4'b0001 << in_addr[1:0];
      end
      2'd1: begin
        st_data = {2{in_wdata[15:0]}};
        st_mask = 4'b0011 << in_addr[1:0];
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half of the read word and extend it
  always_comb begin
    ld_b = mem_resp_rdata[7:0];
    unique case (op_lane)
      2'd0: ld_b = mem_resp_rdata[7:0];
      2'd1: ld_b = mem_resp_rdata[15:8];
      2'd2: ld_b = mem_resp_rdata[23:16];
      2'd3: ld_b = mem_resp_rdata[31:24];
    endcase
    ld_h = op_lane[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    ld_data = mem_resp_rdata;
    unique case (op_f3)
      3'd0: ld_data = {{24{ld_b[7]}}, ld_b};
      3'd1: ld_data = {{16{ld_h[15]}}, ld_h};
      3'd4: ld_data = {24'd0, ld_b};
      3'd5: ld_data = {16'd0, ld_h};
      default: ;
    endcase
  end

  // Operation FSM with registered request and write-back outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      op_load       <= 1'b0;
      op_f3         <= 3'd0;
      op_lane       <= 2'd0;
      op_rd         <= 5'd0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_wdata <= 32'd0;
      mem_req_wmask <= 4'd0;
      lsu_write     <= 1'b0;
      lsu_rd_addr   <= 5'd0;
      lsu_rd_data   <= 32'd0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      lsu_write <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_load <= in_is_load;
            op_f3   <= in_funct3;
            op_lane <= in_addr[1:0];
            op_rd   <= in_rd;
            if (bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state         <= REQ;
              mem_req_wen   <= in_is_store;
              mem_req_addr  <= {in_addr[31:2], 2'b00};
              mem_req_wdata <= st_data;
              mem_req_wmask <= in_is_store ? st_mask : 4'd0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state <= DONE;
            done  <= 1'b1;
            if (op_load) begin
              lsu_write   <= (op_rd != 5'd0);
              lsu_rd_addr <= op_rd;
              lsu_rd_data <= ld_data;
            end
          end else if (cnt == TMAX) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule
